machine_ctl_p: RTL and testbench

//  Parametrised CPU control sequencer; next generation of the 8-state controller.

---
 rtl/machine_ctl_p_pkg.sv | 52 +++++
 rtl/machine_ctl_p_if.sv | 32 +++
 rtl/machine_ctl_p_opclass.sv | 21 ++
 rtl/machine_ctl_p.sv | 161 ++++++++++++++++
 tb/tb_machine_ctl_p.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/machine_ctl_p_pkg.sv
// Shared definitions for the machine_ctl_p control sequencer: opcodes, state
// encodings, strobe bundle and the ALU-read opcode test.
package machine_pkg;

  localparam logic [3:0] OP_HLT = 4'd0;
  localparam logic [3:0] OP_SKZ = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_LDA = 4'd5;
  localparam logic [3:0] OP_STO = 4'd6;
  localparam logic [3:0] OP_JMP = 4'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_NEXT   = 3'd2,
    ST_OPR    = 3'd3,
    ST_EXE    = 3'd4,
    ST_WB     = 3'd5,
    ST_SKP    = 3'd6,
    ST_HALTED = 3'd7
  } state_e;

  typedef struct packed {
    logic is_hlt;
    logic is_skz;
    logic is_jmp;
    logic is_sto;
    logic is_alu;
  } opclass_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } strobes_t;

  // Codes 8..11 only exist as extended ALU reads when the opcode is 4 bits wide.
  function automatic logic is_alu_rd(input logic [3:0] op, input int opw);
    logic res;
    res = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    if (opw == 4 && op[3:2] == 2'b10) res = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/machine_ctl_p_if.sv
// Opcode/flag inputs and registered control strobes of the sequencer.
// All signals are levels; the controller samples inputs and updates outputs on negedge clk.
interface machine_ctl_p_if #(
  parameter int OPW = 3
);
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           mem_ready;
  logic           resume;
  logic           inc_pc;
  logic           load_acc;
  logic           load_pc;
  logic           rd;
  logic           wr;
  logic           load_ir;
  logic           datactl_ena;
  logic           halt;
  logic [1:0]     ir_word;
  logic [2:0]     state_o;

  modport master (
    input  opcode, zero, mem_ready, resume,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt,
    output ir_word, state_o
  );

  modport slave (
    output opcode, zero, mem_ready, resume,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt,
    input  ir_word, state_o
  );
endinterface

// File: rtl/machine_ctl_p_opclass.sv
// Combinational opcode decoder: maps the IR opcode field onto instruction classes.
module machine_opclass
  import machine_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] opcode,
  output opclass_t       cls
);
  logic [3:0] op4;

  always_comb begin
    op4        = 4'(opcode);
    cls        = '0;
    cls.is_hlt = (op4 == OP_HLT);
    cls.is_skz = (op4 == OP_SKZ);
    cls.is_jmp = (op4 == OP_JMP);
    cls.is_sto = (op4 == OP_STO);
    cls.is_alu = is_alu_rd(op4, OPW);
  end
endmodule

// File: rtl/machine_ctl_p.sv
// CPU control sequencer: multi-word fetch, memory wait states, latched halt.
// Outputs are registered and reflect the state being entered at each negedge.
module machine_ctl_p
  import machine_pkg::*;
#(
  parameter int OPW         = 3,
  parameter int INSTR_WORDS = 2,
  parameter int HALT_HOLD   = 1,
  parameter int WAIT_EN     = 1
) (
  input logic              clk,
  input logic              rst,
  machine_ctl_p_if.master  bus
);
  localparam logic [1:0] LAST_WORD = 2'(INSTR_WORDS - 1);
  localparam int         SKP_INC   = INSTR_WORDS - 1;
  localparam int         SKP_LEN   = (INSTR_WORDS > 1) ? INSTR_WORDS - 1 : 1;
  localparam logic [1:0] LAST_SKP  = 2'(SKP_LEN - 1);

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       zero_q, zero_d;
  strobes_t   str_q, str_d;
  logic [1:0] ir_word_q, ir_word_d;
  opclass_t   cls;
  logic       ready;

  machine_opclass #(.OPW(OPW)) u_opclass (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  assign ready = (WAIT_EN != 0) ? bus.mem_ready : 1'b1;

  // cnt_q is the IR word index while fetching and the cycle index while skipping.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    zero_d    = zero_q;
    str_d     = '0;
    ir_word_d = '0;
    case (state_q)
      ST_FETCH: begin
        // rd low here means no access is outstanding yet (just out of reset).
        if (str_q.rd && ready) begin
          if (cnt_q == LAST_WORD) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d         = cnt_q + 2'd1;
            str_d.rd      = 1'b1;
            str_d.load_ir = 1'b1;
            str_d.inc_pc  = 1'b1;
            ir_word_d     = cnt_q + 2'd1;
          end
        end else begin
          str_d.rd      = 1'b1;
          str_d.load_ir = 1'b1;
          ir_word_d     = cnt_q;
        end
      end
      ST_IDLE: begin
        state_d      = ST_NEXT;
        str_d.inc_pc = 1'b1;
        str_d.halt   = cls.is_hlt;
      end
      ST_NEXT: begin
        if (cls.is_hlt && (HALT_HOLD != 0)) begin
          state_d    = ST_HALTED;
          str_d.halt = 1'b1;
        end else begin
          state_d           = ST_OPR;
          str_d.load_pc     = cls.is_jmp;
          str_d.rd          = cls.is_alu;
          str_d.datactl_ena = cls.is_sto;
        end
      end
      ST_HALTED: begin
        if (bus.resume) begin
          state_d       = ST_FETCH;
          cnt_d         = '0;
          str_d.rd      = 1'b1;
          str_d.load_ir = 1'b1;
        end else begin
          str_d.halt = 1'b1;
        end
      end
      ST_OPR: begin
        if (cls.is_alu && !ready) begin
          str_d.rd = 1'b1;
        end else begin
          state_d           = ST_EXE;
          zero_d            = bus.zero;
          str_d.rd          = cls.is_alu;
          str_d.load_acc    = cls.is_alu;
          str_d.inc_pc      = (cls.is_skz && bus.zero) || cls.is_jmp;
          str_d.load_pc     = cls.is_jmp;
          str_d.wr          = cls.is_sto;
          str_d.datactl_ena = cls.is_sto;
        end
      end
      ST_EXE: begin
        if (cls.is_sto && !ready) begin
          str_d.wr          = 1'b1;
          str_d.datactl_ena = 1'b1;
        end else begin
          state_d           = ST_WB;
          str_d.datactl_ena = cls.is_sto;
          str_d.rd          = cls.is_alu;
        end
      end
      ST_WB: begin
        state_d      = ST_SKP;
        cnt_d        = '0;
        str_d.inc_pc = cls.is_skz && zero_q && (SKP_INC > 0);
      end
      ST_SKP: begin
        if (cnt_q == LAST_SKP) begin
          state_d       = ST_FETCH;
          cnt_d         = '0;
          str_d.rd      = 1'b1;
          str_d.load_ir = 1'b1;
        end else begin
          cnt_d        = cnt_q + 2'd1;
          str_d.inc_pc = cls.is_skz && zero_q && ((int'(cnt_q) + 1) < SKP_INC);
        end
      end
      default: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      zero_q    <= 1'b0;
      str_q     <= '0;
      ir_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      zero_q    <= zero_d;
      str_q     <= str_d;
      ir_word_q <= ir_word_d;
    end
  end

  assign bus.inc_pc      = str_q.inc_pc;
  assign bus.load_acc    = str_q.load_acc;
  assign bus.load_pc     = str_q.load_pc;
  assign bus.rd          = str_q.rd;
  assign bus.wr          = str_q.wr;
  assign bus.load_ir     = str_q.load_ir;
  assign bus.datactl_ena = str_q.datactl_ena;
  assign bus.halt        = str_q.halt;
  assign bus.ir_word     = ir_word_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_machine_ctl_p.sv
// Bench for machine_ctl_p: two configurations (defaults; OPW=4/3 words/no halt hold)
// checked cycle by cycle against an instruction-timeline model built from the behaviour rules.
module tb_machine_ctl_p;

  localparam int EW = 10;
  localparam int DW = 7;
  localparam int B_INC = 9;
  localparam int B_ACC = 8;
  localparam int B_WR  = 5;
  localparam int B_HLT = 2;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, sel;
  logic [3:0] opcode;
  logic       zero, mem_ready, resume;

  machine_ctl_p_if #(.OPW(3)) bus_a ();
  machine_ctl_p_if #(.OPW(4)) bus_b ();

  machine_ctl_p #(.OPW(3), .INSTR_WORDS(2), .HALT_HOLD(1), .WAIT_EN(1)) dut_a (
    .clk (clk), .rst (rst_a), .bus (bus_a)
  );
  machine_ctl_p #(.OPW(4), .INSTR_WORDS(3), .HALT_HOLD(0), .WAIT_EN(1)) dut_b (
    .clk (clk), .rst (rst_b), .bus (bus_b)
  );

  assign bus_a.opcode    = opcode[2:0];
  assign bus_a.zero      = zero;
  assign bus_a.mem_ready = mem_ready;
  assign bus_a.resume    = resume;
  assign bus_b.opcode    = opcode;
  assign bus_b.zero      = zero;
  assign bus_b.mem_ready = mem_ready;
  assign bus_b.resume    = resume;

  logic [EW-1:0] obs_a, obs_b, obs;
  assign obs_a = {bus_a.inc_pc, bus_a.load_acc, bus_a.load_pc, bus_a.rd, bus_a.wr,
                  bus_a.load_ir, bus_a.datactl_ena, bus_a.halt, bus_a.ir_word};
  assign obs_b = {bus_b.inc_pc, bus_b.load_acc, bus_b.load_pc, bus_b.rd, bus_b.wr,
                  bus_b.load_ir, bus_b.datactl_ena, bus_b.halt, bus_b.ir_word};
  assign obs   = sel ? obs_b : obs_a;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] drv_q[$];
  int n_checks = 0;
  int n_err    = 0;
  int c_inc, c_acc, c_wr, c_halt;

  task automatic check_vec(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (inc acc lpc rd wr lir dct hlt irw) at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic inc, acc, lpc, rd, wr, lir, dct, hlt,
                                       input int irw);
    logic [1:0] iw;
    iw = 2'(irw);
    return {inc, acc, lpc, rd, wr, lir, dct, hlt, iw};
  endfunction

  function automatic logic [DW-1:0] dv(input logic [3:0] op, input logic mr, z, res);
    return {op, mr, z, res};
  endfunction

  // One instruction as a cycle list: fetch words, IDLE, NEXT, then halt or OPR/EXE/WB/SKP.
  // zero is driven to z through OPR and inverted afterwards so only the latched value counts.
  task automatic model_instr(input int w, hold, opw, input logic [3:0] op, input logic z,
                             input int fwi, fw, ow, ew, hn);
    int  opi;
    int  nw;
    logic hlt, skz, jmp, sto, alu;
    opi = int'(op);
    hlt = (opi == 0);
    skz = (opi == 1);
    jmp = (opi == 7);
    sto = (opi == 6);
    alu = (opi >= 2 && opi <= 5) || (opw == 4 && opi >= 8 && opi <= 11);
    for (int k = 0; k < w; k++) begin
      nw = (k == fwi) ? fw : 0;
      for (int j = 0; j <= nw; j++) begin
        exp_q.push_back(mk(k > 0 && j == 0, 0, 0, 1, 0, 1, 0, 0, k));
        drv_q.push_back(dv(op, j == nw, z, 0));
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    drv_q.push_back(dv(op, 1, z, 0));
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, hlt, 0));
    drv_q.push_back(dv(op, 1, z, 0));
    if (hlt && hold != 0) begin
      for (int j = 0; j < hn; j++) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        drv_q.push_back(dv(op, 1, z, j == hn - 1));
      end
    end else begin
      nw = alu ? ow : 0;
      for (int j = 0; j <= nw; j++) begin
        exp_q.push_back(mk(0, 0, jmp, alu, 0, 0, sto, 0, 0));
        drv_q.push_back(dv(op, j == nw, z, 0));
      end
      nw = sto ? ew : 0;
      for (int j = 0; j <= nw; j++) begin
        exp_q.push_back(mk((skz && z) || jmp, alu, jmp, alu, sto, 0, sto, 0, 0));
        drv_q.push_back(dv(op, j == nw, !z, 0));
      end
      exp_q.push_back(mk(0, 0, 0, alu, 0, 0, sto, 0, 0));
      drv_q.push_back(dv(op, 1, !z, 0));
      for (int j = 0; j < ((w > 1) ? w - 1 : 1); j++) begin
        exp_q.push_back(mk(skz && z && (j < w - 1), 0, 0, 0, 0, 0, 0, 0, 0));
        drv_q.push_back(dv(op, 1, !z, 0));
      end
    end
  endtask

  // Compare process: each posedge checks the outputs set at the previous negedge,
  // then drives the inputs the next negedge will sample.
  task automatic run(input int maxc);
    int n;
    logic [EW-1:0] e;
    logic [DW-1:0] d;
    n = 0;
    c_inc = 0; c_acc = 0; c_wr = 0; c_halt = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      @(posedge clk);
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      check_vec("cycle", obs, e);
      c_inc  += int'(obs[B_INC]);
      c_acc  += int'(obs[B_ACC]);
      c_wr   += int'(obs[B_WR]);
      c_halt += int'(obs[B_HLT]);
      {opcode, mem_ready, zero, resume} = d;
      n++;
    end
  endtask

  task automatic do_instr(input string name, input int cfg, input logic [3:0] op, input logic z,
                          input int fwi, fw, ow, ew, hn,
                          input int e_len, e_inc, e_acc, e_wr, e_halt);
    if (cfg == 0) model_instr(2, 1, 3, op, z, fwi, fw, ow, ew, hn);
    else          model_instr(3, 0, 4, op, z, fwi, fw, ow, ew, hn);
    check_int({name, "_len"}, exp_q.size(), e_len);
    run(1000);
    check_int({name, "_inc"},  c_inc,  e_inc);
    check_int({name, "_acc"},  c_acc,  e_acc);
    check_int({name, "_wr"},   c_wr,   e_wr);
    check_int({name, "_halt"}, c_halt, e_halt);
  endtask

  initial begin
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    opcode = 4'd5; zero = 1'b0; mem_ready = 1'b1; resume = 1'b0;
    repeat (2) begin
      @(posedge clk);
      check_vec("reset_a", obs, '0);
    end
    rst_a = 1'b0;

    //        name        cfg op    z   fwi fw ow ew hn  len inc acc wr halt
    do_instr("a_lda",     0, 4'd5, 0,  0, 0, 0, 0, 0,   8, 2, 1, 0, 0);
    do_instr("a_lda_w",   0, 4'd5, 0,  0, 0, 3, 0, 0,  11, 2, 1, 0, 0);
    do_instr("a_sto_w",   0, 4'd6, 0,  0, 0, 0, 2, 0,  10, 2, 0, 3, 0);
    do_instr("a_skz1",    0, 4'd1, 1,  0, 0, 0, 0, 0,   8, 4, 0, 0, 0);
    do_instr("a_skz0",    0, 4'd1, 0,  0, 0, 0, 0, 0,   8, 2, 0, 0, 0);
    do_instr("a_jmp",     0, 4'd7, 0,  0, 0, 0, 0, 0,   8, 3, 0, 0, 0);
    do_instr("a_add_fw",  0, 4'd2, 1,  1, 2, 0, 0, 0,  10, 2, 1, 0, 0);
    do_instr("a_hlt",     0, 4'd0, 0,  0, 0, 0, 0, 20, 24, 2, 0, 0, 21);
    do_instr("a_xor_fw",  0, 4'd4, 0,  0, 1, 0, 0, 0,   9, 2, 1, 0, 0);
    do_instr("a_and",     0, 4'd3, 1,  0, 0, 0, 0, 0,   8, 2, 1, 0, 0);

    // Reset while a store is in its execute cycle.
    model_instr(2, 1, 3, 4'd6, 1'b0, 0, 0, 0, 5, 0);
    run(6);
    rst_a = 1'b1;
    exp_q.delete();
    drv_q.delete();
    mem_ready = 1'b1;
    @(posedge clk);
    check_vec("rst_in_exe", obs, '0);

    sel = 1'b1;
    check_vec("reset_b", obs, '0);
    rst_b = 1'b0;

    do_instr("b_skz1",    1, 4'd1, 1,  0, 0, 0, 0, 0,  10, 6, 0, 0, 0);
    do_instr("b_skz0",    1, 4'd1, 0,  0, 0, 0, 0, 0,  10, 3, 0, 0, 0);
    do_instr("b_hlt",     1, 4'd0, 0,  0, 0, 0, 0, 0,  10, 3, 0, 0, 1);
    do_instr("b_ext9",    1, 4'd9, 0,  0, 0, 1, 0, 0,  11, 3, 1, 0, 0);
    do_instr("b_nop13",   1, 4'd13, 0, 0, 0, 0, 0, 0,  10, 3, 0, 0, 0);
    do_instr("b_lda_fw",  1, 4'd5, 0,  2, 1, 0, 0, 0,  11, 3, 1, 0, 0);
    do_instr("b_sto_w",   1, 4'd6, 0,  0, 0, 0, 1, 0,  11, 3, 0, 2, 0);
    do_instr("b_jmp",     1, 4'd7, 0,  0, 0, 0, 0, 0,  10, 4, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
